// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/halt sequencer for a 5-stage RV32I pipeline.
// Controls PC and pipeline-register enables for load-use stalls, EX redirects,
// data-memory wait states (with timeout) and halt drain.
// Optional feature: define PIPE_PERF_CNT_EN to add saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned CNT_W        = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       ifid_uses_rs2,
    input  logic       idex_memread,
    input  logic [4:0] idex_rd,
    input  logic       ex_redirect,
    input  logic       ex_halt,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_en,
    output logic       idex_bubble,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       halted,
    output logic       mem_err,
    output logic [1:0] state
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
`endif
);

    localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_DRAIN    = 2'd2,
        S_HALTED   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                err_q, err_d;
    logic                load_use;
    logic                freeze;
    logic                stall_ev;
    logic                flush_ev;

    assign load_use = idex_memread && (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

    assign halted  = (state_q == S_HALTED);
    assign mem_err = err_q;
    assign state   = state_q;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            wait_q  <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    // Next-state and same-cycle control decode
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        drain_d     = drain_q;
        err_d       = err_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_bubble = 1'b0;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        freeze      = 1'b0;
        stall_ev    = 1'b0;
        flush_ev    = 1'b0;

        unique case (state_q)
            S_RUN, S_MEM_WAIT: begin
                // A released MEM_WAIT cycle decodes exactly like RUN
                if ((state_q == S_RUN) ? (dmem_req && !dmem_ready) : !dmem_ready) begin
                    freeze = 1'b1;
                    if (state_q == S_RUN) begin
                        state_d = S_MEM_WAIT;
                        wait_d  = WAIT_W'(1);
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = S_HALTED;
                        err_d   = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    state_d = S_RUN;
                    wait_d  = '0;
                    if (ex_halt) begin
                        pc_en       = 1'b0;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        state_d     = S_DRAIN;
                        drain_d     = DRAIN_INIT;
                    end else if (ex_redirect) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        flush_ev    = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        stall_ev    = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (dmem_req && !dmem_ready) begin
                    freeze = 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        state_d = S_HALTED;
                        err_d   = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    wait_d      = '0;
                    if (drain_q == DRAIN_W'(1)) begin
                        state_d = S_HALTED;
                    end else begin
                        drain_d = drain_q - DRAIN_W'(1);
                    end
                end
            end
            S_HALTED: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
            default: state_d = S_RUN;
        endcase

        if (freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_en     = 1'b0;
            idex_bubble = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
        end

        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_bubble = 1'b1;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            freeze      = 1'b0;
            stall_ev    = 1'b0;
            flush_ev    = 1'b0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign memwait_cnt = memwait_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            if (stall_ev && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_ev && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (freeze && (memwait_cnt_q != '1))
                memwait_cnt_q <= memwait_cnt_q + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed steps then random stimulus
// compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
    logic       ifid_uses_rs2, idex_memread, ex_redirect, ex_halt, dmem_req, dmem_ready;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;
    logic       halted, mem_err;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    // Reference model state: mode 0 run, 1 mem wait, 2 drain, 3 halted
    int m_mode = 0, m_wait = 0, m_drain = 0, m_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(2), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ex_redirect(ex_redirect), .ex_halt(ex_halt),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_bubble(idex_bubble),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .halted(halted), .mem_err(mem_err), .state(state)
    );

    // Expected outputs {pc,ifid_en,flush,idex_en,bubble,exmem,memwb,halted,err,state}
    task automatic model(output logic [10:0] exp, output int nm, output int nw,
                         output int nd, output int ne);
        bit pc = 1, ife = 1, fl = 0, ide = 1, bub = 0, exe = 1, wbe = 1;
        bit lu, frz;
        lu = idex_memread && idex_rd != 0 &&
             (idex_rd == ifid_rs1 || (ifid_uses_rs2 && idex_rd == ifid_rs2));
        nm = m_mode; nw = m_wait; nd = m_drain; ne = m_err;
        if (reset) begin
            {pc, ife, ide, exe, wbe} = '0; fl = 1; bub = 1;
            nm = 0; nw = 0; nd = 0; ne = 0;
        end else if (m_mode == 3) begin
            {pc, ife, ide, exe, wbe} = '0;
        end else if (m_mode == 2) begin
            if (dmem_req && !dmem_ready) begin
                {pc, ife, ide, exe, wbe} = '0;
                if (m_wait == 15) begin nm = 3; ne = 1; end else nw = m_wait + 1;
            end else begin
                pc = 0; ife = 0; bub = 1; nw = 0;
                if (m_drain == 1) nm = 3; else nd = m_drain - 1;
            end
        end else begin
            frz = (m_mode == 0) ? (dmem_req && !dmem_ready) : !dmem_ready;
            if (frz) begin
                {pc, ife, ide, exe, wbe} = '0;
                if (m_mode == 0) begin nm = 1; nw = 1; end
                else if (m_wait == 15) begin nm = 3; ne = 1; end
                else nw = m_wait + 1;
            end else begin
                nm = 0; nw = 0;
                if (ex_halt) begin pc = 0; fl = 1; bub = 1; nm = 2; nd = 2; end
                else if (ex_redirect) begin fl = 1; bub = 1; end
                else if (lu) begin pc = 0; ife = 0; bub = 1; end
            end
        end
        exp = {pc, ife, fl, ide, bub, exe, wbe, (m_mode == 3), (m_err != 0), 2'(m_mode)};
    endtask

    // One clock: check outputs mid-cycle, then advance the model
    task automatic cycle(input string tag);
        logic [10:0] exp, obs;
        int nm, nw, nd, ne;
        @(negedge clk);
        model(exp, nm, nw, nd, ne);
        obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en,
               halted, mem_err, state};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
        @(posedge clk); #1;
        m_mode = nm; m_wait = nw; m_drain = nd; m_err = ne;
    endtask

    task automatic spot(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 0; ifid_rs1 = 0; ifid_rs2 = 0; ifid_uses_rs2 = 0; idex_memread = 0;
        idex_rd = 0; ex_redirect = 0; ex_halt = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        @(posedge clk); #1;
        cycle("reset0");
        cycle("reset1");
        idle();
        cycle("run_idle");
        spot("run_all_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);

        // Load-use stall, then cleared by the bubble
        idex_memread = 1; idex_rd = 5; ifid_rs1 = 5;
        cycle("lu_stall");
        idex_memread = 0;
        cycle("lu_after");
        idex_memread = 1; idex_rd = 0; ifid_rs1 = 0;
        cycle("lu_x0");
        idex_rd = 7; ifid_rs1 = 1; ifid_rs2 = 7; ifid_uses_rs2 = 1;
        cycle("lu_rs2");
        ifid_uses_rs2 = 0;
        cycle("lu_rs2_unused");

        // Redirect overriding load-use
        idex_rd = 5; ifid_rs1 = 5; ex_redirect = 1;
        cycle("redir_lu");
        idle();
        cycle("after_redir");

        // Memory wait of 3 cycles
        dmem_req = 1;
        for (int i = 0; i < 3; i++) cycle("memwait");
        spot("memwait_state", 32'(state), 32'd1);
        dmem_ready = 1;
        cycle("mem_release");
        idle();
        cycle("post_mem");

        // Halt drain, later redirect ignored
        ex_halt = 1;
        cycle("halt_trig");
        ex_halt = 0; ex_redirect = 1;
        for (int i = 0; i < 4; i++) cycle("drain_halt");
        spot("halted_set", 32'(halted), 32'd1);
        idle(); reset = 1;
        cycle("reset_halted");
        idle();

        // Reset mid-DRAIN
        ex_halt = 1;
        cycle("halt2");
        ex_halt = 0;
        cycle("drain2");
        reset = 1;
        cycle("reset_drain");
        reset = 0;
        spot("rst_drain_state", 32'(state), 32'd0);
        cycle("run_after_rst");

        // Reset mid-MEM_WAIT
        dmem_req = 1;
        cycle("mw_a");
        cycle("mw_b");
        reset = 1;
        cycle("reset_mw");
        idle();
        spot("rst_mw_state", {30'd0, halted, mem_err} | (32'(state) << 2), 32'd0);
        cycle("run_after_rst2");

        // Timeout
        dmem_req = 1;
        for (int i = 0; i < 16; i++) cycle("timeout_wait");
        spot("timeout_state", {29'd0, state, halted}, {29'd0, 2'd3, 1'b1});
        dmem_req = 0; dmem_ready = 1; ex_redirect = 1;
        for (int i = 0; i < 3; i++) cycle("timeout_hold");
        spot("mem_err_sticky", 32'(mem_err), 32'd1);
        idle(); reset = 1;
        cycle("reset_err");
        idle();

        // Freeze during drain pauses the drain counter
        ex_halt = 1;
        cycle("halt3");
        ex_halt = 0; dmem_req = 1;
        for (int i = 0; i < 3; i++) cycle("drain_freeze");
        dmem_ready = 1;
        for (int i = 0; i < 3; i++) cycle("drain_resume");

        // Timeout during drain
        idle(); reset = 1;
        cycle("reset4");
        idle(); ex_halt = 1;
        cycle("halt4");
        ex_halt = 0; dmem_req = 1;
        for (int i = 0; i < 17; i++) cycle("drain_timeout");
        spot("drain_timeout_err", 32'(mem_err), 32'd1);

        // Random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 99) < 2) || (m_mode == 3 && $urandom_range(0, 3) == 0);
            ifid_rs1      = 5'($urandom_range(0, 3));
            ifid_rs2      = 5'($urandom_range(0, 3));
            idex_rd       = 5'($urandom_range(0, 3));
            ifid_uses_rs2 = 1'($urandom_range(0, 1));
            idex_memread  = 1'($urandom_range(0, 1));
            ex_redirect   = ($urandom_range(0, 4) == 0);
            ex_halt       = ($urandom_range(0, 29) == 0);
            dmem_req      = ($urandom_range(0, 9) < 3) || (m_mode == 1);
            dmem_ready    = ($urandom_range(0, 9) < 4);
            cycle("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
